// File: rtl/gpr_pkg.sv
// gpr_pkg: shared defaults, register index/data types and popcount for the GPR file.
package gpr_pkg;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int POP_MAX = 256;
   typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;
   typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;
   function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
      popcount = 0;
      for (int k = 0; k < POP_MAX; k++) popcount += 32'(v[k]);
   endfunction
endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: per-register busy bits, issue ready, operand busy flags and busy count.
module gpr_scoreboard
   import gpr_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_RP = 2,
   parameter int NUM_WP = 1,
   parameter int ZERO_REG = 1
)(
   input  logic                             clk,
   input  logic                             rstn_h,
   input  logic [NUM_RP-1:0][ADDR_WIDTH-1:0] rsn,
   input  logic                             iss_vld,
   input  logic [ADDR_WIDTH-1:0]            iss_rdn,
   input  logic [NUM_WP-1:0]                wbe,
   input  logic [NUM_WP-1:0][ADDR_WIDTH-1:0] rdn,
   output logic [NUM_RP-1:0]                rs_busy,
   output logic                             iss_rdy,
   output logic [ADDR_WIDTH:0]              busy_cnt
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   logic [DEPTH-1:0] busy, clr, set, busy_nxt;
   always_comb begin
      clr = '0;
      for (int j = 0; j < NUM_WP; j++) if (wbe[j]) clr[rdn[j]] = 1'b1;
   end
   // a write-back landing this cycle hides the busy bit: the bypass supplies the value
   assign iss_rdy = rstn_h & ~(busy[iss_rdn] & ~clr[iss_rdn]);
   always_comb begin
      set = '0;
      if (iss_vld && iss_rdy && (ZERO_REG == 0 || iss_rdn != '0)) set[iss_rdn] = 1'b1;
      busy_nxt = (busy & ~clr) | set;
   end
   always_comb begin
      for (int i = 0; i < NUM_RP; i++) rs_busy[i] = rstn_h & busy[rsn[i]] & ~clr[rsn[i]];
   end
   always_ff @(posedge clk or negedge rstn_h) begin
      if (!rstn_h) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= (ADDR_WIDTH+1)'(popcount(POP_MAX'(busy_nxt)));
      end
   end
endmodule

// File: rtl/gpr_mp_sb.sv
// gpr_mp_sb: multi-port register file with write-back bypass and an issue scoreboard.
module gpr_mp_sb
   import gpr_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_RP = 2,
   parameter int NUM_WP = 1,
   parameter int ZERO_REG = 1
)(
   input  logic                             clk,
   input  logic                             rstn_h,
   input  logic [NUM_RP-1:0][ADDR_WIDTH-1:0] rsn,
   output logic [NUM_RP-1:0][DATA_WIDTH-1:0] rsd,
   output logic [NUM_RP-1:0]                rs_busy,
   input  logic                             iss_vld,
   input  logic [ADDR_WIDTH-1:0]            iss_rdn,
   output logic                             iss_rdy,
   input  logic [NUM_WP-1:0]                wbe,
   input  logic [NUM_WP-1:0][ADDR_WIDTH-1:0] rdn,
   input  logic [NUM_WP-1:0][DATA_WIDTH-1:0] rdd,
   output logic [ADDR_WIDTH:0]              busy_cnt
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [NUM_WP-1:0] wv;
   always_comb begin
      for (int j = 0; j < NUM_WP; j++) wv[j] = wbe[j] & (ZERO_REG == 0 || rdn[j] != '0);
   end
   // later ports overwrite earlier ones, so the highest index wins
   always_ff @(posedge clk or negedge rstn_h) begin
      if (!rstn_h) begin
         for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
      end else begin
         for (int j = 0; j < NUM_WP; j++) if (wv[j]) regs[rdn[j]] <= rdd[j];
      end
   end
   always_comb begin
      for (int i = 0; i < NUM_RP; i++) begin
         rsd[i] = regs[rsn[i]];
         for (int j = 0; j < NUM_WP; j++) if (wv[j] && rdn[j] == rsn[i]) rsd[i] = rdd[j];
         if (!rstn_h || (ZERO_REG != 0 && rsn[i] == '0)) rsd[i] = '0;
      end
   end
   gpr_scoreboard #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .NUM_RP(NUM_RP),
      .NUM_WP(NUM_WP),
      .ZERO_REG(ZERO_REG)
   ) u_sb (
      .clk(clk),
      .rstn_h(rstn_h),
      .rsn(rsn),
      .iss_vld(iss_vld),
      .iss_rdn(iss_rdn),
      .wbe(wv),
      .rdn(rdn),
      .rs_busy(rs_busy),
      .iss_rdy(iss_rdy),
      .busy_cnt(busy_cnt)
   );
endmodule

// File: doc/gpr_mp_sb.md
Name: gpr_mp_sb

Overview:
- Parametrised multi-port general purpose register file with an integrated scoreboard.
- Provides NUM_RP asynchronous read ports with same-cycle write-back bypass and NUM_WP synchronous write-back ports.
- Adds an issue handshake that marks destination registers busy until write-back.
- Sits between decode/issue and the write-back stage of the core; it is the next generation of the single-write, two-read GPR.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH.
- NUM_RP, 2, number of read ports (1..4).
- NUM_WP, 1, number of write-back ports (1..2).
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never marked busy.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rstn_h  in  1  asynchronous active-low reset.
- rsn  in  NUM_RP x ADDR_WIDTH  read addresses.
- rsd  out  NUM_RP x DATA_WIDTH  read data (combinational).
- rs_busy  out  NUM_RP  source register has a pending producer.
- iss_vld  in  1  issue request for an instruction writing iss_rdn.
- iss_rdn  in  ADDR_WIDTH  destination of the issuing instruction.
- iss_rdy  out  1  issue accepted when iss_vld & iss_rdy.
- wbe  in  NUM_WP  write-back enables.
- rdn  in  NUM_WP x ADDR_WIDTH  write-back addresses.
- rdd  in  NUM_WP x DATA_WIDTH  write-back data.
- busy_cnt  out  ADDR_WIDTH+1  number of registers currently busy.

Behaviour:
- Reset (asynchronous, rstn_h low):
  - All registers are 0, all busy bits are 0, busy_cnt is 0.
  - rsd is forced to 0, rs_busy to 0 and iss_rdy to 0 while rstn_h is low.
  - An issue in flight when reset asserts is discarded.
- Write:
  - On the rising edge, registers[rdn[j]] <= rdd[j] when wbe[j] is set.
  - When ZERO_REG=1, writes with rdn[j]==0 are ignored.
  - Two ports writing the same address in the same cycle: the highest port index wins.
- Read (0 cycles latency, combinational):
  - rsd[i] = rdd[j] when wbe[j] is set and rdn[j]==rsn[i] (valid, nonzero when ZERO_REG); the highest matching j wins.
  - Otherwise rsd[i] = registers[rsn[i]].
  - When ZERO_REG=1, rsn[i]==0 always returns 0.
- Scoreboard, one busy bit per register:
  - Set: on the rising edge when iss_vld & iss_rdy and iss_rdn is valid (nonzero when ZERO_REG).
  - Clear: on the rising edge when any wbe[j] targets that register.
  - Set and clear on the same register in the same cycle: set wins, because a new producer has issued.
- rs_busy[i] = busy[rsn[i]] & ~(a write-back targets rsn[i] this cycle). The bypass supplies the data, so the operand is not reported busy.
- iss_rdy = rstn_h & ~(busy[iss_rdn] & ~(a write-back targets iss_rdn this cycle)). This stalls WAW hazards.
- iss_rdy must not depend on iss_vld, to avoid a combinational loop in the issue stage.
- busy_cnt:
  - Registered, updated each edge as popcount of the next busy vector.
  - Never exceeds DEPTH-1 when ZERO_REG=1, or DEPTH otherwise.
  - No wrap-around.
- A write-back to a non-busy register is legal: data is written and busy stays 0.

Decomposition:
- Package gpr_pkg holds:
  - default DATA_WIDTH and ADDR_WIDTH localparams;
  - typedef reg_idx_t (ADDR_WIDTH bits);
  - typedef reg_data_t (DATA_WIDTH bits);
  - function popcount used for busy_cnt.
- Sub-module gpr_scoreboard contains the busy vector, iss_rdy, rs_busy and busy_cnt logic.
- The data array and bypass mux stay in the top module.

Test Plan:
- Reset mid-operation:
  - Stimulus: write 0xDEADBEEF to r5, issue r7, then drop rstn_h asynchronously mid-cycle.
  - Required: rsd reads 0 immediately, busy_cnt=0, r5 reads 0 after release.
- Zero register:
  - Stimulus: wbe[0]=1, rdn=0, rdd=0xFFFFFFFF, then issue with iss_rdn=0.
  - Required: rsd for r0 stays 0, busy_cnt stays 0, iss_rdy=1.
- Bypass:
  - Stimulus: r3 holds 0x11; in one cycle wbe[0]=1, rdn=3, rdd=0x22 while rsn[0]=3.
  - Required: rsd[0]=0x22 in the same cycle; the next cycle, with wbe=0, rsd[0]=0x22.
- Write-port conflict (NUM_WP=2):
  - Stimulus: both ports write r9 with 0xA and 0xB.
  - Required: r9 reads 0xB.
- Scoreboard WAW:
  - Stimulus: issue r4 (accepted, busy_cnt=1); next cycle iss_vld with r4.
  - Required: iss_rdy=0 and rs_busy=1 for rsn=4.
  - Stimulus: write-back r4 in the same cycle as the re-issue.
  - Required: iss_rdy=1, rs_busy=0, issue accepted, busy[4] remains 1, busy_cnt=1.
- Fill:
  - Stimulus: issue r1..r31 on consecutive cycles.
  - Required: busy_cnt reaches 31 with no wrap; writing back all 31 returns busy_cnt to 0.
